ddr_wr_arb: RTL and testbench
=============================

DDR_WR_ARB -- requirements
Module: ddr_wr_arb

Interface
REQ-001 The block SHALL have parameter ADDR_WIDTH, default 32, meaning DDR byte address width.
REQ-002 The block SHALL have parameter LEN_WIDTH, default 16, meaning transfer length width, in data beats.
REQ-003 The block SHALL have parameter DATA_WIDTH, default 64, meaning write data width.
REQ-004 The block SHALL have one clock and a synchronous, active-high reset: clk (in, 1, rising-edge clock for all logic) and rst (in, 1, synchronous active-high reset).
REQ-005 The block SHALL have, for each requester N in {0,1}, the following ports:
- reqN_start: in, 1, level request, held until reqN_ack.
- reqN_addr: in, ADDR_WIDTH, start address, valid while reqN_start is high.
- reqN_len: in, LEN_WIDTH, beat count, valid while reqN_start is high.
- reqN_ack: out, 1, one-cycle pulse; request accepted.
- reqN_data_vld: in, 1, data beat valid.
- reqN_data: in, DATA_WIDTH, data beat.
- reqN_done: out, 1, one-cycle pulse; transfer complete.
REQ-006 The block SHALL have the following DDR-side ports:
- wstart: out, 1, one-cycle command pulse.
- wready: in, 1, DDR write path idle; wready drops the cycle after wstart and returns high on write completion.
- waddr: out, ADDR_WIDTH, command address.
- wdata_len: out, LEN_WIDTH, command length.
- wdata_vld: out, 1, data beat valid.
- wdata: out, DATA_WIDTH, data beat.

Function
REQ-007 The block SHALL implement an FSM with states IDLE, ISSUE, DATA and DRAIN.
REQ-008 In IDLE with one request high, the block SHALL grant that requester; with both high, it SHALL grant the requester not granted last (round-robin).
REQ-009 On grant, the block SHALL latch reqN_addr and reqN_len into internal registers and go to ISSUE.
REQ-010 A granted request with reqN_len == 0 SHALL pulse reqN_ack in the grant cycle, pulse reqN_done the next cycle, issue no wstart, update the round-robin pointer and return to IDLE.
REQ-011 In ISSUE, the block SHALL wait for wready == 1, then in that cycle assert wstart for exactly one cycle, drive waddr/wdata_len from the latched values, pulse reqN_ack, and go to DATA.
REQ-012 waddr and wdata_len SHALL hold their values from the wstart cycle until the next wstart.
REQ-013 In DATA, only the granted requester's data_vld/data SHALL be forwarded, registered with one cycle latency: wdata_vld(t+1) = reqN_data_vld(t) and wdata(t+1) = reqN_data(t).
REQ-014 A LEN_WIDTH beat counter SHALL increment on each accepted beat; the beat that brings the count to len SHALL be the last beat forwarded, and the FSM SHALL go to DRAIN.
REQ-015 Beats from the non-granted requester, and beats arriving outside DATA, SHALL be discarded (wdata_vld = 0).
REQ-016 In DRAIN, the block SHALL wait for wready == 1, then pulse reqN_done for one cycle, record N as the last grant, and return to IDLE.
REQ-017 A new grant SHALL NOT be issued in the same cycle as reqN_done; the minimum gap between done and the next wstart is 2 cycles.
REQ-018 A request arriving while another transfer is in progress SHALL wait; it SHALL never be dropped.
REQ-019 wdata SHALL be held at its last value whenever wdata_vld = 0.

Reset
REQ-020 On rst = 1 at a clock edge, the FSM SHALL go to IDLE.
REQ-021 On reset, wstart, wdata_vld, req0_ack, req1_ack, req0_done and req1_done SHALL be 0.
REQ-022 On reset, waddr, wdata_len, wdata and the beat counter SHALL be 0.
REQ-023 On reset, the last-grant pointer SHALL be set to 1, so requester 0 wins the first tie.
REQ-024 A reset asserted mid-transfer SHALL abort the transfer with no done pulse; the DDR side is reset by the same rst.

Verification
REQ-025 Single request: req0 addr=0x1000, len=4, wready=1; 4 beats D0..D3 -> one wstart with waddr=0x1000 and wdata_len=4, req0_ack in the same cycle, wdata_vld 4 cycles each delayed 1 cycle, req0_done once wready returns high.
REQ-026 Tie after reset: req0 and req1 both raised with len=2 -> req0 served first, then req1, with two distinct wstart pulses and ack/done order 0,0,1,1.
REQ-027 Fairness: both requesters held continuously for 4 transfers -> grants alternate 0,1,0,1.
REQ-028 Backpressure: wready held 0 for 10 cycles in ISSUE -> no wstart and no ack until wready = 1; in DRAIN, wready = 0 for 5 cycles -> done delayed by exactly 5 cycles.
REQ-029 Zero length: req1 with len=0 -> req1_ack, then req1_done the next cycle, with no wstart.
REQ-030 Reset mid-DATA after 2 of 8 beats: all outputs 0 the next cycle, FSM in IDLE, no done pulse, and a subsequent req1 request is served normally.

Source files
------------

// File: rtl/ddr_wr_arb.sv
// Two-requester round-robin arbiter in front of a single DDR write port.
// One transfer in flight at a time: command, registered data forwarding, drain.
module ddr_wr_arb #(
  parameter int ADDR_WIDTH = 32,
  parameter int LEN_WIDTH  = 16,
  parameter int DATA_WIDTH = 64
) (
  input  logic                  clk,
  input  logic                  rst,

  input  logic                  req0_start,
  input  logic [ADDR_WIDTH-1:0] req0_addr,
  input  logic [LEN_WIDTH-1:0]  req0_len,
  output logic                  req0_ack,
  input  logic                  req0_data_vld,
  input  logic [DATA_WIDTH-1:0] req0_data,
  output logic                  req0_done,

  input  logic                  req1_start,
  input  logic [ADDR_WIDTH-1:0] req1_addr,
  input  logic [LEN_WIDTH-1:0]  req1_len,
  output logic                  req1_ack,
  input  logic                  req1_data_vld,
  input  logic [DATA_WIDTH-1:0] req1_data,
  output logic                  req1_done,

  output logic                  wstart,
  input  logic                  wready,
  output logic [ADDR_WIDTH-1:0] waddr,
  output logic [LEN_WIDTH-1:0]  wdata_len,
  output logic                  wdata_vld,
  output logic [DATA_WIDTH-1:0] wdata
);

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    DATA,
    DRAIN
  } state_t;

  state_t                r_state;
  logic                  r_gnt;
  logic                  r_last;
  logic                  r_zero;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [LEN_WIDTH-1:0]  r_len;
  logic [LEN_WIDTH-1:0]  r_cnt;

  logic                  r_wstart;
  logic [ADDR_WIDTH-1:0] r_waddr;
  logic [LEN_WIDTH-1:0]  r_wlen;
  logic                  r_wvld;
  logic [DATA_WIDTH-1:0] r_wdata;
  logic                  r_ack0;
  logic                  r_ack1;
  logic                  r_done0;
  logic                  r_done1;

  logic                  w_any;
  logic                  w_pick1;
  logic [ADDR_WIDTH-1:0] w_sel_addr;
  logic [LEN_WIDTH-1:0]  w_sel_len;
  logic                  w_len_zero;
  logic                  w_beat_vld;
  logic [DATA_WIDTH-1:0] w_beat;
  logic [LEN_WIDTH-1:0]  w_cnt_nxt;

  // On a tie the requester that did not win last time is picked.
  assign w_any      = req0_start | req1_start;
  assign w_pick1    = req1_start & (~req0_start | ~r_last);
  assign w_sel_addr = w_pick1 ? req1_addr : req0_addr;
  assign w_sel_len  = w_pick1 ? req1_len : req0_len;
  assign w_len_zero = (w_sel_len == '0);

  assign w_beat_vld = r_gnt ? req1_data_vld : req0_data_vld;
  assign w_beat     = r_gnt ? req1_data : req0_data;
  assign w_cnt_nxt  = r_cnt + LEN_WIDTH'(1);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= IDLE;
      r_gnt    <= 1'b0;
      r_last   <= 1'b1;
      r_zero   <= 1'b0;
      r_addr   <= '0;
      r_len    <= '0;
      r_cnt    <= '0;
      r_wstart <= 1'b0;
      r_waddr  <= '0;
      r_wlen   <= '0;
      r_wvld   <= 1'b0;
      r_wdata  <= '0;
      r_ack0   <= 1'b0;
      r_ack1   <= 1'b0;
      r_done0  <= 1'b0;
      r_done1  <= 1'b0;
    end else begin
      r_wstart <= 1'b0;
      r_wvld   <= 1'b0;
      r_ack0   <= 1'b0;
      r_ack1   <= 1'b0;
      r_done0  <= 1'b0;
      r_done1  <= 1'b0;
      unique case (r_state)
        IDLE: begin
          if (w_any) begin
            r_gnt  <= w_pick1;
            r_addr <= w_sel_addr;
            r_len  <= w_sel_len;
            r_cnt  <= '0;
            r_zero <= w_len_zero;
            // Empty transfers never touch the DDR side.
            if (w_len_zero) begin
              r_ack0  <= ~w_pick1;
              r_ack1  <= w_pick1;
              r_last  <= w_pick1;
              r_state <= DRAIN;
            end else begin
              r_state <= ISSUE;
            end
          end
        end
        ISSUE: begin
          if (wready) begin
            r_wstart <= 1'b1;
            r_waddr  <= r_addr;
            r_wlen   <= r_len;
            r_ack0   <= ~r_gnt;
            r_ack1   <= r_gnt;
            r_state  <= DATA;
          end
        end
        DATA: begin
          if (w_beat_vld) begin
            r_wvld  <= 1'b1;
            r_wdata <= w_beat;
            r_cnt   <= w_cnt_nxt;
            if (w_cnt_nxt == r_len) begin
              r_state <= DRAIN;
            end
          end
        end
        DRAIN: begin
          if (wready || r_zero) begin
            r_done0 <= ~r_gnt;
            r_done1 <= r_gnt;
            r_last  <= r_gnt;
            r_zero  <= 1'b0;
            r_state <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign wstart    = r_wstart;
  assign waddr     = r_waddr;
  assign wdata_len = r_wlen;
  assign wdata_vld = r_wvld;
  assign wdata     = r_wdata;
  assign req0_ack  = r_ack0;
  assign req1_ack  = r_ack1;
  assign req0_done = r_done0;
  assign req1_done = r_done1;

endmodule

// File: tb/tb_ddr_wr_arb.sv
// Directed bench for ddr_wr_arb: requester and DDR models stepped per cycle,
// expected values are hand-derived cycle counts and data words.
module tb_ddr_wr_arb;

  logic        clk;
  logic        rst;
  logic        wready;
  logic        wstart;
  logic [31:0] waddr;
  logic [15:0] wdata_len;
  logic        wdata_vld;
  logic [63:0] wdata;
  logic        req0_ack;
  logic        req1_ack;
  logic        req0_done;
  logic        req1_done;

  logic        st[2];
  logic [31:0] ad[2];
  logic [15:0] ln[2];
  logic        dv[2];
  logic [63:0] dat[2];
  int          left[2];
  int          kk[2];
  int          tt[2];
  int          more[2];
  bit          noise[2];

  int          n_checks;
  int          n_err;
  int          cyc;
  int          ddr_cnt;
  int          ddr_lat;
  bit          ddr_hold;
  int          n_wstart;
  int          wstart_cyc;
  int          n_ack[2];
  int          n_done[2];
  int          ack_cyc[2];
  int          done_cyc[2];
  int          first_beat_cyc;
  logic [31:0] last_addr;
  logic [15:0] last_len;
  logic [63:0] beats[$];
  int          evq[$];
  int          ackq[$];

  localparam logic [63:0] BASE  = 64'hDA7A_0000_0000_0000;
  localparam logic [63:0] NOISE = 64'hBAD0_BAD0_BAD0_BAD0;

  ddr_wr_arb dut (
    .clk           (clk),
    .rst           (rst),
    .req0_start    (st[0]),
    .req0_addr     (ad[0]),
    .req0_len      (ln[0]),
    .req0_ack      (req0_ack),
    .req0_data_vld (dv[0]),
    .req0_data     (dat[0]),
    .req0_done     (req0_done),
    .req1_start    (st[1]),
    .req1_addr     (ad[1]),
    .req1_len      (ln[1]),
    .req1_ack      (req1_ack),
    .req1_data_vld (dv[1]),
    .req1_data     (dat[1]),
    .req1_done     (req1_done),
    .wstart        (wstart),
    .wready        (wready),
    .waddr         (waddr),
    .wdata_len     (wdata_len),
    .wdata_vld     (wdata_vld),
    .wdata         (wdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic clear();
    n_wstart       = 0;
    first_beat_cyc = -1;
    beats.delete();
    evq.delete();
    ackq.delete();
    for (int n = 0; n < 2; n++) begin
      n_ack[n]  = 0;
      n_done[n] = 0;
      more[n]   = 0;
      noise[n]  = 1'b0;
    end
  endtask

  task automatic tick();
    logic a;
    logic d;
    @(posedge clk);
    #1;
    cyc++;
    if (rst) ddr_cnt = 0;
    else if (ddr_cnt > 0) ddr_cnt--;
    wready = (ddr_cnt == 0) && !ddr_hold;
    if (wstart) begin
      n_wstart++;
      wstart_cyc = cyc;
      ddr_cnt    = ddr_lat;
      last_addr  = waddr;
      last_len   = wdata_len;
    end
    if (wdata_vld) begin
      if (beats.size() == 0) first_beat_cyc = cyc;
      beats.push_back(wdata);
    end
    for (int n = 0; n < 2; n++) begin
      a = (n == 0) ? req0_ack : req1_ack;
      d = (n == 0) ? req0_done : req1_done;
      if (left[n] > 0) begin
        left[n]--;
        kk[n]++;
      end
      if (a) begin
        evq.push_back(n);
        ackq.push_back(n);
        ack_cyc[n] = cyc;
        tt[n]      = n_ack[n];
        n_ack[n]++;
        st[n]   = 1'b0;
        left[n] = int'(ln[n]);
        kk[n]   = 0;
      end
      if (d) begin
        evq.push_back(2 + n);
        done_cyc[n] = cyc;
        n_done[n]++;
        if (more[n] > 0) begin
          more[n]--;
          st[n] = 1'b1;
        end
      end
      dv[n]  = (left[n] > 0) || noise[n];
      dat[n] = (left[n] > 0) ? BASE + 64'(n * 256 + tt[n] * 16 + kk[n])
                             : NOISE;
    end
  endtask

  task automatic run_done(input int target, input int maxc);
    int i;
    i = 0;
    while ((n_done[0] + n_done[1]) < target && i < maxc) begin
      tick();
      i++;
    end
    chk("done_count", 64'(n_done[0] + n_done[1]), 64'(target));
  endtask

  task automatic do_reset();
    rst = 1'b1;
    for (int n = 0; n < 2; n++) begin
      st[n]   = 1'b0;
      left[n] = 0;
      dv[n]   = 1'b0;
    end
    tick();
    tick();
    rst = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int exp_ev[4];
    int exp_ack[4];
    int rel;
    int i;
    n_checks = 0;
    n_err    = 0;
    cyc      = 0;
    ddr_cnt  = 0;
    ddr_lat  = 3;
    ddr_hold = 1'b0;
    wready   = 1'b1;
    rst      = 1'b1;
    for (int n = 0; n < 2; n++) begin
      st[n] = 1'b0; ad[n] = '0; ln[n] = '0; dv[n] = 1'b0;
      dat[n] = '0; left[n] = 0; kk[n] = 0; tt[n] = 0;
    end
    clear();

    // reset state
    do_reset();
    chk("rst_wstart", 64'(wstart), 0);
    chk("rst_wvld", 64'(wdata_vld), 0);
    chk("rst_ack", 64'({req1_ack, req0_ack}), 0);
    chk("rst_done", 64'({req1_done, req0_done}), 0);
    chk("rst_waddr", 64'(waddr), 0);
    chk("rst_wlen", 64'(wdata_len), 0);
    chk("rst_wdata", wdata, 0);

    // single request with foreign beats from req1 to be discarded
    clear();
    ad[0] = 32'h1000; ln[0] = 16'd4; st[0] = 1'b1;
    noise[1] = 1'b1; dv[1] = 1'b1; dat[1] = NOISE;
    run_done(1, 100);
    noise[1] = 1'b0;
    tick();
    tick();
    chk("t1_wstarts", 64'(n_wstart), 1);
    chk("t1_waddr", 64'(last_addr), 64'h1000);
    chk("t1_wlen", 64'(last_len), 4);
    chk("t1_ack_at_wstart", 64'(ack_cyc[0]), 64'(wstart_cyc));
    chk("t1_first_beat", 64'(first_beat_cyc), 64'(wstart_cyc + 1));
    chk("t1_nbeats", 64'(beats.size()), 4);
    for (int b = 0; b < 4 && b < beats.size(); b++)
      chk("t1_beat", beats[b], BASE + 64'(b));
    chk("t1_done_lat", 64'(done_cyc[0] - wstart_cyc), 5);
    chk("t1_no_ack1", 64'(n_ack[1]), 0);
    chk("t1_hold_vld", 64'(wdata_vld), 0);
    chk("t1_hold_data", wdata, BASE + 64'd3);
    chk("t1_hold_addr", 64'(waddr), 64'h1000);

    // tie right after reset
    do_reset();
    clear();
    ad[0] = 32'h100; ln[0] = 16'd2; st[0] = 1'b1;
    ad[1] = 32'h200; ln[1] = 16'd2; st[1] = 1'b1;
    run_done(2, 200);
    exp_ev = '{0, 2, 1, 3};
    chk("t2_nev", 64'(evq.size()), 4);
    for (int e = 0; e < 4 && e < evq.size(); e++)
      chk("t2_order", 64'(evq[e]), 64'(exp_ev[e]));
    chk("t2_wstarts", 64'(n_wstart), 2);
    chk("t2_nbeats", 64'(beats.size()), 4);
    if (beats.size() == 4) begin
      chk("t2_b0", beats[0], BASE + 64'h000);
      chk("t2_b1", beats[1], BASE + 64'h001);
      chk("t2_b2", beats[2], BASE + 64'h100);
      chk("t2_b3", beats[3], BASE + 64'h101);
    end

    // both held continuously: grants alternate
    clear();
    ln[0] = 16'd1; ln[1] = 16'd1;
    st[0] = 1'b1; st[1] = 1'b1;
    more[0] = 1; more[1] = 1;
    run_done(4, 400);
    exp_ack = '{0, 1, 0, 1};
    chk("t3_nack", 64'(ackq.size()), 4);
    for (int e = 0; e < 4 && e < ackq.size(); e++)
      chk("t3_rr", 64'(ackq[e]), 64'(exp_ack[e]));
    chk("t3_wstarts", 64'(n_wstart), 4);

    // backpressure in ISSUE
    clear();
    ddr_hold = 1'b1;
    tick();
    ad[0] = 32'h3000; ln[0] = 16'd1; st[0] = 1'b1;
    repeat (10) tick();
    chk("t4_no_wstart", 64'(n_wstart), 0);
    chk("t4_no_ack", 64'(n_ack[0]), 0);
    ddr_hold = 1'b0;
    tick();
    rel = cyc;
    run_done(1, 100);
    chk("t4_wstart_cyc", 64'(wstart_cyc), 64'(rel + 1));
    chk("t4_drain_base", 64'(done_cyc[0] - wstart_cyc), 4);

    // backpressure in DRAIN: 5 extra cycles of wready low
    clear();
    ddr_lat = 8;
    ln[0] = 16'd1; st[0] = 1'b1;
    run_done(1, 100);
    chk("t4_drain_slow", 64'(done_cyc[0] - wstart_cyc), 9);
    ddr_lat = 3;
    tick();
    tick();

    // zero length
    clear();
    ln[1] = 16'd0; st[1] = 1'b1;
    run_done(1, 50);
    chk("t5_ack", 64'(n_ack[1]), 1);
    chk("t5_done_next", 64'(done_cyc[1] - ack_cyc[1]), 1);
    chk("t5_no_wstart", 64'(n_wstart), 0);
    chk("t5_no_beats", 64'(beats.size()), 0);

    // reset after 2 of 8 beats
    clear();
    ad[0] = 32'h4000; ln[0] = 16'd8; st[0] = 1'b1;
    i = 0;
    while (beats.size() < 2 && i < 100) begin
      tick();
      i++;
    end
    chk("t6_two_beats", 64'(beats.size()), 2);
    rst = 1'b1;
    for (int n = 0; n < 2; n++) begin
      st[n] = 1'b0; left[n] = 0; dv[n] = 1'b0;
    end
    tick();
    chk("t6_wstart", 64'(wstart), 0);
    chk("t6_wvld", 64'(wdata_vld), 0);
    chk("t6_ack", 64'({req1_ack, req0_ack}), 0);
    chk("t6_done", 64'({req1_done, req0_done}), 0);
    chk("t6_waddr", 64'(waddr), 0);
    chk("t6_wlen", 64'(wdata_len), 0);
    chk("t6_wdata", wdata, 0);
    rst = 1'b0;
    repeat (5) tick();
    chk("t6_no_done", 64'(n_done[0]), 0);
    clear();
    ad[1] = 32'h2000; ln[1] = 16'd3; st[1] = 1'b1;
    run_done(1, 100);
    chk("t6_waddr2", 64'(last_addr), 64'h2000);
    chk("t6_wlen2", 64'(last_len), 3);
    chk("t6_nbeats", 64'(beats.size()), 3);
    if (beats.size() == 3)
      chk("t6_last_beat", beats[2], BASE + 64'h102);
    chk("t6_done1", 64'(n_done[1]), 1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
